inst_ram_loader: RTL and testbench

- Writer side of the instruction-memory interface that the CPU fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words into the instruction RAM at consecutive byte addresses.
- Holds the CPU in reset while loading, so programs are installed in hardware rather than by $readmemh.

---
 rtl/inst_ram_loader.sv | 153 +++++++++++++++
 tb/tb_inst_ram_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_loader.sv
// Byte-stream loader that writes big-endian words into the instruction RAM and holds the CPU in
// reset until a load completes. Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte.
module inst_ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_start,
  input  logic [LEN_W-1:0] i_load_len,
  input  logic             i_in_valid,
  input  logic [7:0]       i_in_data,
  output logic             o_in_ready,
  output logic             o_ram_we,
  output logic [31:0]      o_ram_addr,
  output logic [31:0]      o_ram_data,
  output logic             o_cpu_rst,
  output logic             o_load_done,
  output logic             o_load_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
`endif

  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_cnt;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_shift;
  logic [31:0]      r_ram_addr;
  logic [31:0]      r_ram_data;
  logic             r_cpu_rst;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       r_xor;
  logic             r_err;
`endif

  logic             w_in_ready;
  logic             w_xfer;
  logic [LEN_W-1:0] w_len_clamped;
  logic [LEN_W-1:0] w_word_next;
  logic [31:0]      w_word_off;

`ifdef LOADER_CHECKSUM_EN
  assign w_in_ready = (r_state == S_RECV) || (r_state == S_CHECK);
`else
  assign w_in_ready = (r_state == S_RECV);
`endif
  assign w_xfer        = i_in_valid & w_in_ready;
  assign w_len_clamped = (32'(i_load_len) > MAX_WORDS) ? LEN_W'(MAX_WORDS) : i_load_len;
  assign w_word_next   = r_word_cnt + LEN_W'(1);
  // Byte offset of the current word; 32-bit add below wraps naturally.
  assign w_word_off    = 32'(r_word_cnt) << 2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_ram_addr <= BASE_ADDR;
      r_ram_data <= '0;
      r_cpu_rst  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      r_xor      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load_start) begin
            r_len      <= w_len_clamped;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_cpu_rst  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= '0;
            r_err      <= 1'b0;
            r_state    <= (w_len_clamped == '0) ? S_CHECK : S_RECV;
`else
            r_state    <= (w_len_clamped == '0) ? S_DONE : S_RECV;
`endif
          end
        end
        S_RECV: begin
          if (w_xfer) begin
            r_shift <= {r_shift[15:0], i_in_data};
`ifdef LOADER_CHECKSUM_EN
            r_xor   <= r_xor ^ i_in_data;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_ram_data <= {r_shift, i_in_data};
              r_ram_addr <= BASE_ADDR + w_word_off;
              r_byte_cnt <= '0;
              r_state    <= S_WRITE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        S_WRITE: begin
          r_word_cnt <= w_word_next;
          if (w_word_next == r_len) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CHECK;
`else
            r_state <= S_DONE;
`endif
          end else begin
            r_state <= S_RECV;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_xfer) begin
            if (i_in_data != r_xor) r_err <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
`ifdef LOADER_CHECKSUM_EN
          r_cpu_rst <= r_err;
`else
          r_cpu_rst <= 1'b0;
`endif
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_ram_we    = (r_state == S_WRITE);
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_data  = r_ram_data;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_load_done = (r_state == S_DONE);
`ifdef LOADER_CHECKSUM_EN
  assign o_load_err  = r_err;
`else
  assign o_load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_inst_ram_loader.sv
// Scoreboard bench for inst_ram_loader: expected RAM writes are queued as bytes are driven and
// popped by a write monitor.
module tb_inst_ram_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [15:0] load_len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, ram_we, cpu_rst, load_done, load_err;
  logic [31:0] ram_addr, ram_data;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [7:0]  tb_xor = '0;

  inst_ram_loader #(
    .BASE_ADDR(32'h0000_0000),
    .LEN_W    (16),
    .MAX_WORDS(4)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load_start(load_start),
    .i_load_len  (load_len),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_data  (ram_data),
    .o_cpu_rst   (cpu_rst),
    .o_load_done (load_done),
    .o_load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Write monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        we_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h, none expected", ram_addr, ram_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({ram_addr, ram_data} !== mon_exp) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                     ram_addr, ram_data, mon_exp[63:32], mon_exp[31:0]);
          end
        end
      end
      if (load_done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic start_load(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 16'(len);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    tb_xor     = '0;
    checks++;
    if (cpu_rst !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL start_flags: got cpu_rst=%b load_err=%b, expected 1 0", cpu_rst, load_err);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL byte_accept: in_ready=%b after %0d cycles, expected 1", in_ready, k);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tb_xor   = tb_xor ^ b;
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input int gap, input bit poke);
    exp_q.push_back({32'(idx * 4), w});
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready: got in_ready=%b, expected 1", in_ready);
          end
          @(posedge clk);
          #1;
        end
      end
      if (poke && i == 1) begin
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 16'd1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
      end
    end
  endtask

  task automatic finish_load(input bit bad_csum);
    int  k;
    int  d0;
    bit  exp_err;
    exp_err = bad_csum && CSUM_EN;
    d0 = done_cnt;
    if (CSUM_EN) send_byte(tb_xor ^ {7'd0, bad_csum});
    k = 0;
    @(negedge clk);
    while (!load_done && k < 60) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL done_wait: load_done=%b after %0d cycles, expected 1", load_done, k);
    end
    checks++;
    if (cpu_rst !== 1'b1 || load_err !== exp_err) begin
      errors++;
      $display("FAIL done_cycle: got cpu_rst=%b load_err=%b, expected 1 %b",
               cpu_rst, load_err, exp_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d writes outstanding, expected 0", exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (cpu_rst !== exp_err || load_err !== exp_err || load_done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got cpu_rst=%b load_err=%b load_done=%b, expected %b %b 0",
               cpu_rst, load_err, load_done, exp_err, exp_err);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d, expected 1", done_cnt - d0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #20;
    @(negedge clk);
    checks++;
    if ({in_ready, ram_we, cpu_rst, load_done, load_err} !== 5'b00100 ||
        ram_addr !== 32'h0 || ram_data !== 32'h0) begin
      errors++;
      $display("FAIL reset: got rdy=%b we=%b crst=%b done=%b err=%b addr=%h data=%h, expected 0 0 1 0 0 0 0",
               in_ready, ram_we, cpu_rst, load_done, load_err, ram_addr, ram_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    start_load(2);
    send_word(32'h3401_0001, 0, 0, 1'b0);
    send_word(32'h3401_0002, 1, 0, 1'b0);
    finish_load(1'b0);
  endtask

  task automatic test_stall();
    start_load(2);
    send_word(32'h3401_0001, 0, 3, 1'b0);
    send_word(32'h3401_0002, 1, 3, 1'b0);
    finish_load(1'b0);
  endtask

  task automatic test_zero_len();
    int w0;
    w0 = we_cnt;
    start_load(0);
    finish_load(1'b0);
    checks++;
    if (we_cnt != w0) begin
      errors++;
      $display("FAIL zero_len_writes: got %0d writes, expected 0", we_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [39:0] partial;
    partial = 40'h11_2233_4455;
    start_load(3);
    exp_q.push_back({32'h0, 32'h1122_3344});
    for (int i = 0; i < 5; i++) send_byte(partial[39-8*i -: 8]);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1 || in_ready !== 1'b0 || ram_we !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got crst=%b rdy=%b we=%b done=%b, expected 1 0 0 0",
               cpu_rst, in_ready, ram_we, load_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_writes: %0d writes outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start_load(1);
    send_word(32'hAABB_CCDD, 0, 0, 1'b0);
    finish_load(1'b0);
  endtask

  task automatic test_ignored_start_clamp();
    int w0;
    w0 = we_cnt;
    start_load(9);
    send_word(32'h0102_0304, 0, 0, 1'b1);
    send_word(32'h0506_0708, 1, 0, 1'b0);
    send_word(32'h090A_0B0C, 2, 0, 1'b0);
    send_word(32'h0D0E_0F10, 3, 0, 1'b0);
    finish_load(1'b0);
    checks++;
    if (we_cnt - w0 != 4) begin
      errors++;
      $display("FAIL clamp_writes: got %0d writes, expected 4", we_cnt - w0);
    end
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 32'hC || ram_data !== 32'h0D0E_0F10) begin
      errors++;
      $display("FAIL hold_outputs: got we=%b addr=%h data=%h, expected 0 0000000c 0d0e0f10",
               ram_we, ram_addr, ram_data);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    start_load(1);
    send_word(32'h1234_5678, 0, 0, 1'b0);
    finish_load(1'b0);
    start_load(1);
    send_word(32'h1234_5678, 0, 0, 1'b0);
    finish_load(1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_reset_mid_load();
    test_ignored_start_clamp();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
